bcd_counter_seq: RTL

Sequencer for a cascade of mod-10 decade counters. It divides `clk` into count ticks, ripples BCD carries across DIGITS decades, and runs a start/stop/clear/load command FSM. It compares the count against a programmable target and signals completion. It sits between user control logic (buttons or host registers) and display or downstream logic that consumes the BCD digits.

---
 rtl/bcd_counter_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bcd_counter_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_seq
// Function : Prescaled cascade of BCD decade counters with a
//            start/stop/clear/load sequencer and target-match detection.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_seq #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] target,
    input  logic                auto_reload,
    output logic [4*DIGITS-1:0] count,
    output logic                tick,
    output logic                running,
    output logic                done,
    output logic                overflow
);

    localparam int                c_PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_PRESC_W-1:0]   r_presc;

    logic [DIGITS:0]        w_carry;
    logic [4*DIGITS-1:0]    w_inc;
    logic [4*DIGITS-1:0]    w_load_sat;
    logic [DIGITS-1:0]      w_tgt_ok;
    logic                   w_wrap;
    logic                   w_match;
    logic                   w_advance;

    assign w_carry[0] = 1'b1;

    // Digit i advances only when every lower digit is 9.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] w_d;
        logic [3:0] w_lv;
        assign w_d                 = count[4*i +: 4];
        assign w_lv                = load_val[4*i +: 4];
        assign w_carry[i+1]        = w_carry[i] & (w_d == 4'd9);
        assign w_inc[4*i +: 4]     = !w_carry[i]      ? w_d  :
                                     (w_d == 4'd9)    ? 4'd0 : w_d + 4'd1;
        assign w_load_sat[4*i +: 4] = (w_lv > 4'd9) ? 4'd9 : w_lv;
        assign w_tgt_ok[i]         = (target[4*i +: 4] <= 4'd9);
    end

    assign w_wrap    = w_carry[DIGITS];
    assign w_match   = (&w_tgt_ok) && (w_inc == target);
    // A load in RUN is ignored but still outranks stop, so counting carries on.
    assign w_advance = (r_state == S_RUN) && !clear && (load || !stop);

    always_ff @(posedge clk) begin
        tick     <= 1'b0;
        done     <= 1'b0;
        overflow <= 1'b0;
        if (!reset) begin
            r_state <= S_IDLE;
            count   <= '0;
            r_presc <= '0;
            running <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            count   <= '0;
            r_presc <= '0;
            running <= 1'b0;
        end else if (w_advance) begin
            if (r_presc == c_PRESC_LAST) begin
                r_presc <= '0;
                tick    <= 1'b1;
                if (w_match) begin
                    done     <= 1'b1;
                    overflow <= w_wrap & ~auto_reload;
                    if (auto_reload) begin
                        count <= '0;
                    end else begin
                        count   <= target;
                        r_state <= S_DONE;
                        running <= 1'b0;
                    end
                end else begin
                    count    <= w_inc;
                    overflow <= w_wrap;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end else if (load) begin
            count <= w_load_sat;
            if (r_state == S_DONE) begin
                r_state <= S_PAUSE;
            end
        end else if (stop) begin
            if (r_state == S_RUN) begin
                r_state <= S_PAUSE;
                running <= 1'b0;
            end
        end else if (start) begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                    r_presc <= '0;
                    running <= 1'b1;
                end
                S_PAUSE: begin
                    r_state <= S_RUN;
                    running <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_RUN;
                    count   <= '0;
                    r_presc <= '0;
                    running <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
